// File: rtl/fetch_aligner.sv
// fetch_aligner: fetch-side instruction aligner for an RV32IC pipeline.
//   Reads word-aligned lines from imem, buffers them as halfwords, and presents
//   one aligned 16- or 32-bit instruction with its PC to decode per handshake.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   imem_read/addr/rdata/resp     single-outstanding word fetch interface
//   flush, flush_pc               one-cycle redirect to a halfword-aligned target
//   valid_out, ready_in           decode handshake
//   ir_out, pc_out                instruction (compressed zero-extended; nop when invalid) and its PC
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter int unsigned BUF_HW   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [31:0] ir_out,
  output logic [31:0] pc_out
);

  localparam int unsigned CW = $clog2(BUF_HW + 1);
  localparam int unsigned AW = $clog2(BUF_HW);

  // F_STALE: a request is still outstanding but its data belongs to a
  // pre-flush stream and must be discarded when it returns.
  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_STALE} fetch_e;

  fetch_e        fst_q, fst_d;
  logic [15:0]   buf_q [BUF_HW];
  logic [15:0]   buf_d [BUF_HW];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   tgt_q, tgt_d;
  logic          drop_lo_q, drop_lo_d;

  logic          is32, valid, accept;
  logic [15:0]   h0, h1, push0, push1;
  logic [31:0]   flush_word;
  int unsigned   cnt_w, pop_w, push_w;
  logic          unused_flush_pc0;

  assign unused_flush_pc0 = flush_pc[0];

  assign h0    = buf_q[0];
  assign h1    = buf_q[1];
  assign is32  = (h0[1:0] == 2'b11);
  assign cnt_w = 32'(cnt_q);
  assign valid = is32 ? (cnt_w >= 2) : (cnt_w >= 1);

  assign valid_out = valid;
  assign ir_out    = !valid ? 32'h0000_0013 : (is32 ? {h1, h0} : {16'h0000, h0});
  assign pc_out    = pc_q;
  assign imem_addr = addr_q;
  assign imem_read = (fst_q != F_IDLE);

  assign accept     = imem_resp && (fst_q == F_WAIT) && !flush;
  assign push0      = drop_lo_q ? imem_rdata[31:16] : imem_rdata[15:0];
  assign push1      = imem_rdata[31:16];
  assign pop_w      = (valid && ready_in) ? (is32 ? 2 : 1) : 0;
  assign push_w     = accept ? (drop_lo_q ? 1 : 2) : 0;
  assign flush_word = {flush_pc[31:2], 2'b00};

  always_comb begin
    int unsigned j;
    j         = 0;
    fst_d     = fst_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    tgt_d     = tgt_q;
    drop_lo_d = drop_lo_q;

    // Shift out popped halfwords and append pushed ones in a single pass, so
    // a simultaneous push and pop land in the right slots.
    for (int unsigned i = 0; i < BUF_HW; i++) begin
      j = i + pop_w;
      if (j < cnt_w)                       buf_d[i] = buf_q[AW'(j)];
      else if (j == cnt_w && push_w >= 1)  buf_d[i] = push0;
      else if (j == cnt_w + 1 && push_w == 2) buf_d[i] = push1;
      else                                 buf_d[i] = '0;
    end

    if (flush) begin
      cnt_d     = '0;
      pc_d      = {flush_pc[31:1], 1'b0};
      drop_lo_d = flush_pc[1];
      case (fst_q)
        F_IDLE: addr_d = flush_word;
        default: begin
          if (imem_resp) begin
            addr_d = flush_word;
            fst_d  = F_IDLE;
          end else begin
            // Keep the bus request stable; remember where to go afterwards.
            fst_d = F_STALE;
            tgt_d = flush_word;
          end
        end
      endcase
    end else begin
      cnt_d = CW'(cnt_w + push_w - pop_w);
      if (pop_w != 0) pc_d = pc_q + (is32 ? 32'd4 : 32'd2);
      case (fst_q)
        F_IDLE:  if (cnt_w <= BUF_HW - 2) fst_d = F_WAIT;
        F_WAIT: begin
          if (imem_resp) begin
            addr_d    = addr_q + 32'd4;
            drop_lo_d = 1'b0;
            fst_d     = F_IDLE;
          end
        end
        F_STALE: begin
          if (imem_resp) begin
            addr_d = tgt_q;
            fst_d  = F_IDLE;
          end
        end
        default: fst_d = F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fst_q     <= F_IDLE;
      cnt_q     <= '0;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      tgt_q     <= RESET_PC;
      drop_lo_q <= 1'b0;
      for (int unsigned i = 0; i < BUF_HW; i++) buf_q[i] <= '0;
    end else begin
      fst_q     <= fst_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      tgt_q     <= tgt_d;
      drop_lo_q <= drop_lo_d;
      for (int unsigned i = 0; i < BUF_HW; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
module tb_fetch_aligner;

  logic        clk, rst_n;
  logic        imem_read, imem_resp, flush, valid_out, ready_in;
  logic [31:0] imem_addr, imem_rdata, flush_pc, ir_out, pc_out;

  logic        w_read, w_resp, w_valid, w_ready;
  logic [31:0] w_addr, w_rdata, w_ir, w_pc;

  fetch_aligner #(.RESET_PC(32'h0000_0060), .BUF_HW(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_read(imem_read), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp), .flush(flush), .flush_pc(flush_pc),
    .valid_out(valid_out), .ready_in(ready_in), .ir_out(ir_out), .pc_out(pc_out)
  );

  fetch_aligner #(.RESET_PC(32'hFFFF_FFFC), .BUF_HW(3)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_read(w_read), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .imem_resp(w_resp), .flush(1'b0), .flush_pc(32'h0),
    .valid_out(w_valid), .ready_in(w_ready), .ir_out(w_ir), .pc_out(w_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    int unsigned min_resp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [logic [31:0]];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned resp_cnt = 0, req_cnt = 0;
  logic [31:0] last_req = '0, hold_addr = '0;
  bit          mem_en = 0, busy = 0, w_busy = 0, hold_en = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_inst(input logic [31:0] ir, input logic [31:0] pc, input int unsigned minr);
    exp_t e;
    e.ir = ir; e.pc = pc; e.min_resp = minr;
    sb.push_back(e);
  endtask

  // imem model for the main instance: one outstanding request, optional hold.
  initial begin
    logic [31:0] a;
    imem_resp = 0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_en && rst_n && imem_read) begin
        busy = 1; a = imem_addr; req_cnt++; last_req = a;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        while (hold_en && a == hold_addr) @(negedge clk);
        check_eq("addr_stable", imem_addr, a);
        @(posedge clk); #1;
        imem_resp  = 1;
        imem_rdata = mem.exists(a) ? mem[a] : 32'h0001_0001;
        resp_cnt++;
        @(posedge clk); #1;
        imem_resp = 0; busy = 0;
      end
    end
  end

  // imem model for the wrap-around instance.
  initial begin
    logic [31:0] wa;
    w_resp = 0; w_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_en && rst_n && w_read) begin
        w_busy = 1; wa = w_addr;
        @(posedge clk); #1;
        w_resp  = 1;
        w_rdata = (wa == 32'hFFFF_FFFC) ? 32'h4581_4501 : 32'h0001_0001;
        @(posedge clk); #1;
        w_resp = 0; w_busy = 0;
      end
    end
  end

  // Scoreboard: compare every accepted instruction against the queue head.
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_in) begin
      if (sb.size() == 0) begin
        check_eq("extra_inst_pc", pc_out, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("ir", ir_out, e.ir);
        check_eq("pc", pc_out, e.pc);
        check_eq("resp_before_valid", 32'(resp_cnt >= e.min_resp), 32'd1);
      end
    end
  end

  task automatic do_reset();
    mem_en = 0; hold_en = 0; ready_in = 0; flush = 0; flush_pc = '0; w_ready = 0;
    for (int k = 0; k < 20 && (busy || w_busy); k++) @(posedge clk);
    check_eq("model_idle", {30'b0, busy, w_busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 0; #2;
    check_eq("rst_valid", 32'(valid_out), 32'd0);
    check_eq("rst_read", 32'(imem_read), 32'd0);
    check_eq("rst_ir", ir_out, 32'h0000_0013);
    check_eq("rst_pc", pc_out, 32'h0000_0060);
    check_eq("rst_addr", imem_addr, 32'h0000_0060);
    check_eq("rst_w_addr", w_addr, 32'hFFFF_FFFC);
    sb.delete(); mem.delete(); resp_cnt = 0; req_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1; mem_en = 1;
  endtask

  task automatic run_expect(input string tag, input int unsigned budget);
    int unsigned k;
    k = 0;
    ready_in = 1;
    while (sb.size() != 0 && k < budget) begin
      @(posedge clk); k++;
    end
    #1 ready_in = 0;
    check_eq(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr, input int unsigned budget);
    bit found;
    found = 0;
    for (int unsigned k = 0; k < budget && !found; k++) begin
      @(negedge clk);
      if (imem_read && imem_addr == addr) found = 1;
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  initial begin
    int unsigned k;
    bit seen;
    rst_n = 1; ready_in = 0; flush = 0; flush_pc = '0; w_ready = 0;

    // 1: single 32-bit instruction, then next fetch address
    do_reset();
    mem[32'h60] = 32'h00A0_0093;
    expect_inst(32'h00A0_0093, 32'h60, 1);
    run_expect("t1_drain", 50);
    check_eq("t1_next_addr", imem_addr, 32'h64);

    // 2: two compressed instructions in one word
    do_reset();
    mem[32'h60] = 32'h4581_4501;
    expect_inst(32'h0000_4501, 32'h60, 1);
    expect_inst(32'h0000_4581, 32'h62, 1);
    run_expect("t2_drain", 50);

    // 3: 32-bit instruction straddling two words
    do_reset();
    mem[32'h60] = 32'h0013_4505;
    mem[32'h64] = 32'h0000_0513;
    expect_inst(32'h0000_4505, 32'h60, 1);
    expect_inst(32'h0513_0013, 32'h62, 2);
    run_expect("t3_drain", 60);

    // 4: flush to 0x102 while the read of 0x68 is outstanding
    do_reset();
    hold_en = 1; hold_addr = 32'h68;
    mem[32'h68]  = 32'h1111_1111;
    mem[32'h100] = 32'h4581_1111;
    for (int unsigned i = 0; i < 4; i++) expect_inst(32'h0000_0001, 32'h60 + 2 * i, (i < 2) ? 1 : 2);
    run_expect("t4_prefill", 80);
    wait_req("t4_req68", 32'h68, 40);
    @(posedge clk); #1;
    flush = 1; flush_pc = 32'h102;
    @(posedge clk); #1;
    flush = 0;
    check_eq("t4_read_held", 32'(imem_read), 32'd1);
    check_eq("t4_addr_held", imem_addr, 32'h68);
    check_eq("t4_valid", 32'(valid_out), 32'd0);
    check_eq("t4_pc", pc_out, 32'h102);
    k = req_cnt;
    hold_en = 0;
    seen = 0;
    for (int unsigned i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (req_cnt == k + 1) seen = 1;
    end
    check_eq("t4_reissue", 32'(seen), 32'd1);
    check_eq("t4_new_addr", last_req, 32'h100);
    check_eq("t4_stale_dropped", 32'(valid_out), 32'd0);
    expect_inst(32'h0000_4581, 32'h102, 4);
    run_expect("t4_drain", 50);

    // 5: backpressure with a full queue
    do_reset();
    mem[32'h60] = 32'h4581_4501;
    mem[32'h64] = 32'h4601_4505;
    for (int unsigned i = 0; i < 60 && resp_cnt < 2; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("t5_read_low", 32'(imem_read), 32'd0);
      check_eq("t5_ir_hold", ir_out, 32'h0000_4501);
      check_eq("t5_pc_hold", pc_out, 32'h60);
    end
    expect_inst(32'h0000_4501, 32'h60, 2);
    expect_inst(32'h0000_4581, 32'h62, 2);
    expect_inst(32'h0000_4505, 32'h64, 2);
    expect_inst(32'h0000_4601, 32'h66, 2);
    @(posedge clk); #1;
    run_expect("t5_drain", 20);

    // 6a: flush in the same cycle as a response
    do_reset();
    hold_en = 1; hold_addr = 32'h60;
    mem[32'h60]  = 32'h4581_4501;
    mem[32'h200] = 32'h00A0_0093;
    wait_req("t6_req60", 32'h60, 20);
    hold_en = 0;
    seen = 0;
    for (int unsigned i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (imem_resp) seen = 1;
    end
    check_eq("t6_resp_seen", 32'(seen), 32'd1);
    flush = 1; flush_pc = 32'h201;
    @(posedge clk); #1;
    flush = 0;
    check_eq("t6_read", 32'(imem_read), 32'd0);
    check_eq("t6_addr", imem_addr, 32'h200);
    check_eq("t6_pc", pc_out, 32'h200);
    check_eq("t6_valid", 32'(valid_out), 32'd0);
    expect_inst(32'h00A0_0093, 32'h200, 2);
    run_expect("t6_drain", 50);

    // 6b: fetch address wraps past 32'hFFFF_FFFC
    do_reset();
    seen = 0;
    for (int unsigned i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (w_valid) seen = 1;
    end
    check_eq("w_valid", 32'(seen), 32'd1);
    check_eq("w_addr_wrap", w_addr, 32'h0);
    check_eq("w_ir0", w_ir, 32'h0000_4501);
    check_eq("w_pc0", w_pc, 32'hFFFF_FFFC);
    check_eq("w_read_full", 32'(w_read), 32'd0);
    @(posedge clk); #1 w_ready = 1;
    @(posedge clk); #1 w_ready = 0;
    check_eq("w_pc1", w_pc, 32'hFFFF_FFFE);
    check_eq("w_ir1", w_ir, 32'h0000_4581);
    seen = 0;
    for (int unsigned i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (w_read) seen = 1;
    end
    check_eq("w_refetch", 32'(seen), 32'd1);
    check_eq("w_refetch_addr", w_addr, 32'h0);

    mem_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
